// File: rtl/snn_enc_pkg.sv
// Shared definitions for the rate-coding spike encoder.
package snn_enc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_HOLD = 2'd2
  } enc_state_e;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/lif_spike_enc_lfsr16.sv
// 16-bit Galois LFSR with synchronous load and step enable.
import snn_enc_pkg::*;

module lfsr16 #(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Load has priority over stepping so a new run always starts from the seed.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (step) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // State register; reset parks the generator at the default seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // An all-zero seed would lock the LFSR at zero forever.
  always_ff @(posedge clk) begin
    if (!rst && load) begin
      assert (seed != 16'h0);
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/lif_spike_enc.sv
// Rate-coding spike encoder: one channel compared per GEN cycle, then the
// finished vector is held until the layer FSM acknowledges the timestep.
import snn_enc_pkg::*;

module lif_spike_enc #(
  parameter int          N_CH    = 30,
  parameter int          PIX_W   = 8,
  parameter int          T_STEPS = 16,
  parameter logic [15:0] SEED    = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_wr,
  input  logic [4:0]        pix_addr,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              start,
  input  logic              step_ack,
  output logic              spk_valid,
  output logic [N_CH-1:0]   spikes_out_bits,
  output logic [4:0]        t_idx,
  output logic              busy,
  output logic              done
);

  enc_state_e        state_q, state_d;
  logic [4:0]        ch_q, ch_d;
  logic [4:0]        t_q, t_d;
  logic [N_CH-1:0]   spk_q, spk_d;
  logic [N_CH-2:0]   shadow_q, shadow_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;

  logic [N_CH*PIX_W-1:0] pix_flat;
  logic                  wr_en;
  logic [15:0]           lfsr_q;
  logic                  lfsr_unused;
  logic [PIX_W-1:0]      cur_pix;
  logic                  cur_bit;

  assign wr_en = (state_q == ST_IDLE) && pix_wr && (pix_addr < 5'(N_CH));

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_pix
      logic [PIX_W-1:0] pix_q, pix_d;

      // Per-channel intensity register, writable only while idle.
      always_comb begin
        pix_d = pix_q;
        if (wr_en && (pix_addr == 5'(gi))) begin
          pix_d = pix_data;
        end
      end

      // Pixel register update; reset clears the stored frame.
      always_ff @(posedge clk) begin
        if (rst) begin
          pix_q <= '0;
        end else begin
          pix_q <= pix_d;
        end
      end

      assign pix_flat[gi*PIX_W +: PIX_W] = pix_q;
    end
  endgenerate

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load ((state_q == ST_IDLE) && start),
    .seed (SEED),
    .step (state_q == ST_GEN),
    .q    (lfsr_q)
  );

  // Only the low PIX_W bits take part in the intensity compare.
  assign lfsr_unused = ^lfsr_q[15:PIX_W];
  assign cur_pix     = pix_flat[ch_q*PIX_W +: PIX_W];
  assign cur_bit     = (lfsr_q[PIX_W-1:0] < cur_pix);

  // Next-state and datapath control for IDLE -> GEN -> HOLD sequencing.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    t_d      = t_q;
    spk_d    = spk_q;
    shadow_d = shadow_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_GEN;
          ch_d    = '0;
          t_d     = '0;
          spk_d   = '0;
          valid_d = 1'b0;
        end
      end
      ST_GEN: begin
        if (ch_q == 5'(N_CH-1)) begin
          // Publish the whole vector at once so the consumer never sees a partial one.
          spk_d   = {cur_bit, shadow_q};
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          shadow_d[ch_q] = cur_bit;
          ch_d           = ch_q + 5'd1;
        end
      end
      ST_HOLD: begin
        if (step_ack) begin
          valid_d = 1'b0;
          if (t_q == 5'(T_STEPS-1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            t_d     = t_q + 5'd1;
            ch_d    = '0;
            state_d = ST_GEN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      t_q      <= '0;
      spk_q    <= '0;
      shadow_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      t_q      <= t_d;
      spk_q    <= spk_d;
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign spk_valid       = valid_q;
  assign spikes_out_bits = spk_q;
  assign t_idx           = t_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;

endmodule
